// File: rtl/dtcm_ahb_slave_pkg.sv
// dtcm_ahb_slave_pkg: AHB encodings, FSM state encoding and byte-enable helper shared by the DTCM slave
package dtcm_ahb_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_HAZ  = 3'd4;
    localparam logic [2:0] ST_ERR1 = 3'd5;
    localparam logic [2:0] ST_ERR2 = 3'd6;

    // Little-endian lane mask; sizes above a word fall back to all four lanes
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        return (size == HSIZE_BYTE) ? 4'b0001 << a :
               (size == HSIZE_HALF) ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    endfunction

endpackage

// File: rtl/dtcm_ahb_slave_sram.sv
// dtcm_sram: single-port synchronous-read word RAM with per-byte write enables (contents never reset)
module dtcm_sram #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [3:0]            i_we,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    // Lane-masked write and registered read on the same port
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/dtcm_ahb_slave.sv
// dtcm_ahb_slave: AHB-Lite data TCM slave with optional wait states; DTCM_ERR_RESP_EN enables ERROR responses
module dtcm_ahb_slave
    import dtcm_ahb_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int WAIT_CYC   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    logic [2:0]            r_state, w_next, w_acc_state;
    logic [2:0]            r_cnt, r_size;
    logic [DEPTH_LOG2-1:0] r_addr, w_ram_addr;
    logic                  r_write;
    logic [3:0]            r_be, w_we;
    logic [31:0]           r_hold, w_ram_q;
    logic                  w_ready, w_accept, w_err, w_unused;

    assign w_ready  = r_state inside {ST_IDLE, ST_RD, ST_WR, ST_ERR2};
    assign w_accept = hsel & htrans[1] & hready_in & w_ready;

`ifdef DTCM_ERR_RESP_EN
    assign w_err = (|haddr[31:DEPTH_LOG2+2]) | ((hsize == HSIZE_HALF) & haddr[0]) |
                   ((hsize == HSIZE_WORD) & (|haddr[1:0])) | (hsize > HSIZE_WORD);
    assign hresp = (r_state == ST_ERR1) | (r_state == ST_ERR2);
`else
    assign w_err = 1'b0;
    assign hresp = 1'b0;
`endif

    assign w_unused = ^{hburst, hprot, r_size, haddr[31:DEPTH_LOG2+2]};

    // A read landing on a write data phase cannot use the busy RAM port, so it takes a HAZ bubble
    always_comb begin
        w_acc_state = w_err ? ST_ERR1 : (WAIT_CYC > 0) ? ST_WAIT : hwrite ? ST_WR :
                      (r_state == ST_WR) ? ST_HAZ : ST_RD;
        w_next = r_state;
        case (r_state)
            ST_WAIT: if (r_cnt == 3'd0) w_next = r_write ? ST_WR : ST_RD;
            ST_HAZ:  w_next = ST_RD;
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = w_accept ? w_acc_state : ST_IDLE;
        endcase
    end

    // State, captured address phase, wait counter and the hrdata hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_be    <= 4'd0;
            r_hold  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= haddr[DEPTH_LOG2+1:2];
                r_write <= hwrite;
                r_size  <= hsize;
                r_be    <= byte_en(hsize, haddr[1:0]);
                r_cnt   <= 3'(WAIT_CYC - 1);
            end else if (r_state == ST_WAIT && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (r_state == ST_RD) r_hold <= w_ram_q;
        end
    end

    assign w_ram_addr = (r_state inside {ST_WR, ST_WAIT, ST_HAZ}) ? r_addr : haddr[DEPTH_LOG2+1:2];
    assign w_we       = (r_state == ST_WR) ? r_be : 4'd0;
    assign hrdata     = (r_state == ST_RD) ? w_ram_q : r_hold;
    assign hreadyout  = w_ready;

    dtcm_sram #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_we),
        .i_wdata (hwdata),
        .o_rdata (w_ram_q)
    );

endmodule

// File: tb/tb_dtcm_ahb_slave.sv
// tb_dtcm_ahb_slave: directed bench for zero-wait and three-wait DTCM slaves; honours DTCM_ERR_RESP_EN
module tb_dtcm_ahb_slave;
    import dtcm_ahb_slave_pkg::*;

    logic        clk, rst_n, hsel0, hsel3, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] hrdata0, hrdata3;
    logic        hready0, hready3, hresp0, hresp3;
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] exp_w0;

    dtcm_ahb_slave #(.DEPTH_LOG2(12), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready_in(hready0), .hrdata(hrdata0), .hreadyout(hready0), .hresp(hresp0)
    );

    dtcm_ahb_slave #(.DEPTH_LOG2(12), .WAIT_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready_in(hready3), .hrdata(hrdata3), .hreadyout(hready3), .hresp(hresp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ap(input logic s0, input logic s3, input logic w, input logic [31:0] a, input logic [2:0] sz);
        hsel0 = s0; hsel3 = s3; hwrite = w; haddr = a; hsize = sz; htrans = HTRANS_NONSEQ;
    endtask

    task automatic idle();
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = HTRANS_IDLE;
    endtask

    initial begin
        rst_n = 1'b0; hwrite = 1'b0; haddr = 32'd0; hwdata = 32'd0; hsize = HSIZE_WORD;
        hburst = 3'd0; hprot = 4'd0; idle();
        repeat (3) tick();
        chk("rst_rdy0", 32'(hready0), 32'd1);
        chk("rst_resp0", 32'(hresp0), 32'd0);
        chk("rst_rdata0", hrdata0, 32'd0);
        chk("rst_rdata3", hrdata3, 32'd0);
        rst_n = 1'b1;
        tick();
        hsel0 = 1'b1; htrans = HTRANS_BUSY;
        tick();
        chk("busy_rdy", 32'(hready0), 32'd1);
        chk("busy_resp", 32'(hresp0), 32'd0);
        // write then immediately read the same word: one HAZ bubble
        ap(1, 0, 1, 32'h10, HSIZE_WORD); tick();
        chk("w10_rdy", 32'(hready0), 32'd1);
        hwdata = 32'hDEADBEEF; ap(1, 0, 0, 32'h10, HSIZE_WORD); tick();
        chk("haz_rdy", 32'(hready0), 32'd0);
        idle(); tick();
        chk("raw_rdy", 32'(hready0), 32'd1);
        chk("raw_data", hrdata0, 32'hDEADBEEF);
        tick();
        chk("hold_idle", hrdata0, 32'hDEADBEEF);
        // byte write on lane 2 over a full word
        ap(1, 0, 1, 32'h10, HSIZE_WORD); tick();
        hwdata = 32'h11223344; ap(1, 0, 1, 32'h12, HSIZE_BYTE);
        chk("bw_rdy", 32'(hready0), 32'd1); tick();
        hwdata = 32'h00AA0000; idle();
        chk("bw2_rdy", 32'(hready0), 32'd1); tick();
        ap(1, 0, 0, 32'h10, HSIZE_WORD); tick();
        idle();
        chk("bw_data", hrdata0, 32'h11AA3344); tick();
        // four back-to-back writes then four back-to-back reads
        ap(1, 0, 1, 32'h0, HSIZE_WORD); tick();
        for (int i = 1; i < 4; i++) begin
            hwdata = 32'hA000_0000 + 32'(i - 1); ap(1, 0, 1, 32'(4 * i), HSIZE_WORD);
            chk("b2bw_rdy", 32'(hready0), 32'd1); tick();
        end
        hwdata = 32'hA000_0003; ap(1, 0, 0, 32'h0, HSIZE_WORD);
        chk("b2bw_last_rdy", 32'(hready0), 32'd1); tick();
        chk("b2b_haz", 32'(hready0), 32'd0);
        ap(1, 0, 0, 32'h4, HSIZE_WORD); tick();
        for (int i = 0; i < 4; i++) begin
            chk("b2br_rdy", 32'(hready0), 32'd1);
            chk("b2br_data", hrdata0, 32'hA000_0000 + 32'(i));
            if (i == 1 || i == 2) ap(1, 0, 0, 32'(4 * (i + 1)), HSIZE_WORD);
            else if (i == 3) idle();
            tick();
        end
        // out-of-range address: ERROR when enabled, otherwise wraps to word 0
        ap(1, 0, 0, 32'h0001_0000, HSIZE_WORD); tick();
        idle();
`ifdef DTCM_ERR_RESP_EN
        chk("err1_rdy", 32'(hready0), 32'd0);
        chk("err1_resp", 32'(hresp0), 32'd1); tick();
        chk("err2_rdy", 32'(hready0), 32'd1);
        chk("err2_resp", 32'(hresp0), 32'd1); tick();
        chk("post_err_rdy", 32'(hready0), 32'd1);
        chk("post_err_resp", 32'(hresp0), 32'd0);
        exp_w0 = 32'hA000_0000;
`else
        chk("wrap_rdy", 32'(hready0), 32'd1);
        chk("wrap_resp", 32'(hresp0), 32'd0);
        chk("wrap_data", hrdata0, 32'hA000_0000); tick();
        exp_w0 = 32'hBADB_AD00;
`endif
        ap(1, 0, 1, 32'h0001_0000, HSIZE_WORD); tick();
        hwdata = 32'hBADB_AD00; idle(); tick();
`ifdef DTCM_ERR_RESP_EN
        tick();
`endif
        ap(1, 0, 0, 32'h0, HSIZE_WORD); tick();
        idle();
        chk("ram_w0", hrdata0, exp_w0); tick();
        // three wait states on both write and read
        ap(0, 1, 1, 32'h20, HSIZE_WORD); hwdata = 32'h12345678; tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("w3w_wait", 32'(hready3), 32'd0); tick();
        end
        chk("w3w_done", 32'(hready3), 32'd1);
        ap(0, 1, 0, 32'h20, HSIZE_WORD); tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("w3r_wait", 32'(hready3), 32'd0); tick();
        end
        chk("w3r_rdy", 32'(hready3), 32'd1);
        chk("w3r_data", hrdata3, 32'h12345678); tick();
        // reset during the wait states of a write abandons it
        ap(0, 1, 1, 32'h20, HSIZE_WORD); hwdata = 32'hCAFEF00D; tick();
        idle();
        chk("rst_pre_rdy", 32'(hready3), 32'd0);
        rst_n = 1'b0; #1;
        chk("rst_mid_rdy", 32'(hready3), 32'd1);
        chk("rst_mid_data", hrdata3, 32'd0);
        tick(); tick();
        rst_n = 1'b1; tick();
        ap(0, 1, 0, 32'h20, HSIZE_WORD); tick();
        idle();
        repeat (3) tick();
        chk("rst_old_rdy", 32'(hready3), 32'd1);
        chk("rst_old_data", hrdata3, 32'h12345678);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
